// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit.
// Signed ops are reduced to magnitudes at start and the sign is restored in FIX.
// Multiply is shift-add over WIDTH cycles, divide is restoring shift-subtract.
// {pa,pb} is the shared working register:
//   multiply: pa = running upper partial sum, pb = multiplier shifting out / product low bits
//   divide:   pa = partial remainder, pb = dividend shifting out / quotient bits shifting in
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;   // latched op[1]
  logic             neg_res;  // product / quotient must be negated
  logic             neg_rem;  // remainder takes the dividend's (negative) sign
  logic             dz;       // divisor was zero for this operation
  logic [WIDTH-1:0] m;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0] pa;
  logic [WIDTH-1:0] pb;

  // operand magnitudes at launch (signed ops only take absolute values)
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    sgn_a = ~op[0] & operandA[WIDTH-1];
    sgn_b = ~op[0] & operandB[WIDTH-1];
    mag_a = sgn_a ? (~operandA + 1'b1) : operandA;
    mag_b = sgn_b ? (~operandB + 1'b1) : operandB;
  end

  // one iteration of shift-add (multiply) or restoring shift-subtract (divide)
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   r_sh;
  logic             r_ge;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] pa_nx, pb_nx;

  always_comb begin
    mul_sum = {1'b0, pa} + (pb[0] ? {1'b0, m} : '0);
    r_sh    = {pa, pb[WIDTH-1]};
    r_ge    = r_sh >= {1'b0, m};
    // when r_ge holds the difference is below m, so modulo-2^WIDTH is exact
    r_diff  = r_sh[WIDTH-1:0] - m;
    if (is_div) begin
      pa_nx = r_ge ? r_diff : r_sh[WIDTH-1:0];
      pb_nx = {pb[WIDTH-2:0], r_ge};
    end else begin
      pa_nx = mul_sum[WIDTH:1];
      pb_nx = {mul_sum[0], pb[WIDTH-1:1]};
    end
  end

  // sign correction of the finished magnitudes
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_res ? (~{pa, pb} + 1'b1) : {pa, pb};
    quo_fix  = neg_res ? (~pb + 1'b1) : pb;
    rem_fix  = neg_rem ? (~pa + 1'b1) : pa;
  end

  // control FSM with registered busy/done/divByZero and HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      dz        <= 1'b0;
      m         <= '0;
      pa        <= '0;
      pb        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // start wins over same-edge MTHI/MTLO strobes
            state     <= CALC;
            cnt       <= '0;
            busy      <= 1'b1;
            divByZero <= 1'b0;
            is_div    <= op[1];
            neg_res   <= sgn_a ^ sgn_b;
            neg_rem   <= sgn_a;
            dz        <= op[1] & (operandB == '0);
            m         <= op[1] ? mag_b : mag_a;
            pa        <= '0;
            pb        <= op[1] ? mag_a : mag_b;
          end else begin
            if (hiWrite) hi <= writeData;
            if (loWrite) lo <= writeData;
          end
        end
        CALC: begin
          pa  <= pa_nx;
          pb  <= pb_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
            cnt   <= '0;
          end
        end
        FIX: begin
          if (is_div) begin
            if (dz) begin
              divByZero <= 1'b1;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/divByZero
// computed with plain arithmetic; a monitor pops and compares on every done.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, hiWrite, loWrite;
  logic [1:0]  op;
  logic [31:0] operandA, operandB, writeData;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB),
    .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
    .busy(busy), .done(done), .divByZero(divByZero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mhi = '0, mlo = '0;
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference: architectural HI/LO semantics from plain arithmetic
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    e.dz = 1'b0;
    case (o)
      2'b00: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; mhi = p[63:32]; mlo = p[31:0]; end
      2'b10: if (b == 0) e.dz = 1'b1;
             else begin sq = sa / sb; sr = sa % sb; mlo = sq[31:0]; mhi = sr[31:0]; end
      default: if (b == 0) e.dz = 1'b1;
               else begin mlo = a / b; mhi = a % b; end
    endcase
    e.hi = mhi;
    e.lo = mlo;
    return e;
  endfunction

  // monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no outstanding op");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_hi", hi, e.hi);
        chk("res_lo", lo, e.lo);
        chk("res_dz", 32'(divByZero), 32'(e.dz));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
  endtask

  // launch one op; optional injection of a start+hiWrite while busy, or
  // strobes on the same edge as start
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inject, input bit strobe);
    int bc;
    bit seen;
    wait_idle();
    q.push_back(model(o, a, b));
    start = 1'b1; op = o; operandA = a; operandB = b;
    if (strobe) begin hiWrite = 1'b1; loWrite = 1'b1; writeData = $urandom; end
    @(negedge clk);
    start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
    operandA = $urandom; operandB = $urandom;
    chk("dz_cleared", 32'(divByZero), 32'd0);
    bc = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == inject) begin
        start = 1'b1; op = 2'b10; operandA = $urandom; operandB = $urandom;
        hiWrite = 1'b1; writeData = $urandom;
      end else if (i == inject + 1) begin
        start = 1'b0; hiWrite = 1'b0;
      end
      if (done) begin seen = 1'b1; break; end
      if (busy) bc++;
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_cycles", 32'(bc), 32'd33);
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
  endtask

  task automatic mt(input bit hw, input bit lw, input logic [31:0] d);
    wait_idle();
    hiWrite = hw; loWrite = lw; writeData = d;
    @(negedge clk);
    hiWrite = 1'b0; loWrite = 1'b0;
    if (hw) mhi = d;
    if (lw) mlo = d;
    chk("mt_hi", hi, mhi);
    chk("mt_lo", lo, mlo);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = 32'(unsigned'($urandom_range(0, 20)));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; operandA = '0; operandB = '0;
    hiWrite = 1'b0; loWrite = 1'b0; writeData = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(divByZero), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, -5, 1'b0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -5, 1'b0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    run_op(2'b11, 32'd100, 32'd7, -5, 1'b0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -5, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -5, 1'b0);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    // MTHI then divide by zero leaves HI/LO untouched
    mt(1'b1, 1'b0, 32'h1234_5678);
    run_op(2'b11, 32'd5, 32'd0, -5, 1'b0);
    chk("dz_flag", 32'(divByZero), 32'd1);
    chk("dz_hi", hi, 32'h1234_5678);
    run_op(2'b01, 32'd2, 32'd3, -5, 1'b0);  // dz_cleared checked at launch

    // start and hiWrite while busy are ignored
    run_op(2'b00, 32'd3, 32'd4, 5, 1'b0);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd12);

    // both strobes, then strobes on the same edge as start (start wins)
    mt(1'b1, 1'b1, 32'hA5A5_5A5A);
    run_op(2'b11, 32'd9, 32'd0, -5, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] o;
      o = 2'($urandom_range(0, 3));
      run_op(o, pick(), pick(), -5, 1'b0);
      if (n % 10 == 3) mt($urandom_range(0, 1) == 1, 1'b1, $urandom);
    end

    // reset mid-operation aborts with no done
    wait_idle();
    q.push_back(model(2'b00, 32'd123, 32'd456));
    start = 1'b1; op = 2'b00; operandA = 32'd123; operandB = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    q.delete();
    mhi = '0; mlo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_busy_after", 32'(busy), 32'd0);
    chk("abort_hi_after", hi, 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit sitting directly downstream of the register file in the datapath.
- Consumes readData1 (rs) and readData2 (rt) as operands for MULT/MULTU/DIV/DIVU, computes over 32 cycles, and holds results in internal HI/LO registers read by MFHI/MFLO.
- Also accepts MTHI/MTLO writes.
- Control asserts start for one cycle; the unit reports busy and pulses done.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  launch operation in op; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- operandA  input  WIDTH  rs value (readData1): multiplicand or dividend
- operandB  input  WIDTH  rt value (readData2): multiplier or divisor
- hiWrite  input  1  MTHI strobe
- loWrite  input  1  MTLO strobe
- writeData  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO are updated (or a divide-by-zero is flagged)
- divByZero  output  1  last divide had divisor 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous assert, synchronous release on clk): state IDLE, hi=0, lo=0, busy=0, done=0, divByZero=0, counter=0. Reset during CALC/FIX aborts; no done is produced.
- States:
  - IDLE: start=1 at edge E0 latches op, captures |operandA| and |operandB| (signed ops) or raw values (unsigned ops), and latches the result sign(s). Goes to CALC with count=0; busy=1 after E0; divByZero is cleared.
  - CALC: one iteration per edge; after the edge where count==WIDTH-1 the state goes to FIX.
    - Multiply is shift-add on a 2*WIDTH accumulator.
    - Divide is restoring shift-subtract, giving a WIDTH quotient and a WIDTH remainder.
  - FIX, edge E0+WIDTH+1:
    - MULT: negate the 64-bit product if the operand signs differ.
    - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
    - Multiply: hi = upper half, lo = lower half.
    - Divide: lo = quotient, hi = remainder.
    - Then done=1 for exactly one cycle, busy=0, state returns to IDLE.
- Latency: done is high in the cycle after edge E0+33 for WIDTH=32. The next start is accepted in that same done cycle.
- Divide by zero (operandB==0 with op DIV/DIVU): full 33-cycle latency; hi/lo are NOT modified; divByZero=1 with done and held until the next accepted start.
- DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- start while busy: ignored; latched operands unaffected.
- hiWrite/loWrite:
  - In IDLE, hi/lo take writeData at the edge.
  - Ignored while busy.
  - Same-edge start in IDLE: start wins and the strobes are dropped.
  - hiWrite and loWrite together: both written.
- hi/lo are stable while busy and hold their previous values until FIX.
- Operand inputs are sampled only at E0; they may change afterwards.

Test Plan:
- MULT operandA=7, operandB=0xFFFFFFFD (-3) -> after 33 cycles done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIVU 100/7 -> lo=14, hi=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 in IDLE, then DIVU 5/0 -> done with divByZero=1; hi=0x12345678, lo unchanged; the next start clears divByZero.
- Start MULT 3x4, then at cycle 5 pulse start with op DIV and new operands, and hiWrite=1 -> both ignored; result hi=0, lo=12.
- Start MULT, drive reset=0 at cycle 10 for one cycle -> hi=lo=0 immediately, busy=0, no done afterwards.
